// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer
//   Control sequencer for one forward pass of a layered network. Each layer
//   contains n_out neurons. Each neuron takes n_in multiply-accumulate beats.
//   For every beat it drives the weight-RAM read and the MAC controls. For
//   every neuron it hands off to the activation unit and then writes the
//   result to the layer output buffer.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   start                 begin a pass (sampled only while idle)
//   n_in, n_out           size of layer layer_sel (external config, latched in CFG)
//   act_done              activation unit finished current neuron
//   layer_sel             current layer index
//   w_addr, w_re          weight-RAM read address / enable
//   in_idx                input-vector index paired with w_addr
//   mac_clr, mac_en       accumulator clear-and-load / accumulate (RAM data valid)
//   act_start             one-cycle activation start pulse
//   out_we, out_idx       output-buffer write strobe and neuron index
//   busy                  high whenever a pass is in progress
//   done                  one-cycle pulse at end of pass
module layer_mac_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int IDX_W      = 6,
  parameter int NUM_LAYERS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_in,
  input  logic [IDX_W-1:0]  n_out,
  input  logic              act_done,
  output logic [1:0]        layer_sel,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_re,
  output logic [IDX_W-1:0]  in_idx,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              act_start,
  output logic              out_we,
  output logic [IDX_W-1:0]  out_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CFG   = 3'd1;
  localparam logic [2:0] MAC   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] ACT   = 3'd4;
  localparam logic [2:0] WRITE = 3'd5;
  localparam logic [2:0] NEXT  = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  localparam logic [1:0]        LAST_LAYER = 2'(NUM_LAYERS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [1:0]        LAYER_ONE  = 2'd1;

  logic [2:0]       state;
  logic [IDX_W-1:0] n_in_r;
  logic [IDX_W-1:0] n_out_r;

  // Strobes decode directly from the state register, so a synchronous reset
  // forces every one of them low on the following cycle.
  assign w_re      = (state == MAC);
  assign act_start = (state == DRAIN);
  assign out_we    = (state == WRITE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      layer_sel <= '0;
      w_addr    <= '0;
      in_idx    <= '0;
      out_idx   <= '0;
      n_in_r    <= '0;
      n_out_r   <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
    end else begin
      // RAM read latency is one cycle: the MAC controls trail the read by one.
      mac_en  <= (state == MAC);
      mac_clr <= (state == MAC) && (in_idx == '0);

      case (state)
        IDLE: begin
          if (start) begin
            state     <= CFG;
            w_addr    <= '0;
            layer_sel <= '0;
          end
        end
        CFG: begin
          n_in_r  <= n_in;
          n_out_r <= n_out;
          out_idx <= '0;
          in_idx  <= '0;
          if ((n_in == '0) || (n_out == '0)) state <= NEXT;
          else                               state <= MAC;
        end
        MAC: begin
          w_addr <= w_addr + ADDR_ONE;
          in_idx <= in_idx + IDX_ONE;
          if (in_idx == n_in_r - IDX_ONE) state <= DRAIN;
        end
        DRAIN: state <= ACT;
        ACT: begin
          if (act_done) state <= WRITE;
        end
        WRITE: begin
          if (out_idx == n_out_r - IDX_ONE) begin
            state <= NEXT;
          end else begin
            out_idx <= out_idx + IDX_ONE;
            in_idx  <= '0;
            state   <= MAC;
          end
        end
        NEXT: begin
          if (layer_sel == LAST_LAYER) begin
            state <= FIN;
          end else begin
            layer_sel <= layer_sel + LAYER_ONE;
            state     <= CFG;
          end
        end
        FIN: begin
          layer_sel <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Testbench for layer_mac_sequencer. A pass-level model expands each layer
// configuration into the expected per-cycle activity (layer -> neuron -> beat),
// including the stimulus it implies (start, act_done, config), and one loop
// drives and checks two instances (ADDR_W=10 and ADDR_W=4) against it.
module tb_layer_mac_sequencer;

  localparam int AW  = 10;
  localparam int AW4 = 4;
  localparam int IW  = 6;
  localparam int NL  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, act_done = 1'b0;
  logic [IW-1:0] n_in = '0, n_out = '0;

  logic [1:0] ls_a, ls_b;
  logic [AW-1:0] addr_a;
  logic [AW4-1:0] addr_b;
  logic [IW-1:0] iidx_a, iidx_b, oidx_a, oidx_b;
  logic wre_a, clr_a, en_a, ast_a, we_a, busy_a, done_a;
  logic wre_b, clr_b, en_b, ast_b, we_b, busy_b, done_b;

  always #5 clk = ~clk;

  layer_mac_sequencer #(.ADDR_W(AW), .IDX_W(IW), .NUM_LAYERS(NL)) dut (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in), .n_out(n_out),
    .act_done(act_done), .layer_sel(ls_a), .w_addr(addr_a), .w_re(wre_a),
    .in_idx(iidx_a), .mac_clr(clr_a), .mac_en(en_a), .act_start(ast_a),
    .out_we(we_a), .out_idx(oidx_a), .busy(busy_a), .done(done_a));

  layer_mac_sequencer #(.ADDR_W(AW4), .IDX_W(IW), .NUM_LAYERS(NL)) dut4 (
    .clk(clk), .reset(reset), .start(start), .n_in(n_in), .n_out(n_out),
    .act_done(act_done), .layer_sel(ls_b), .w_addr(addr_b), .w_re(wre_b),
    .in_idx(iidx_b), .mac_clr(clr_b), .mac_en(en_b), .act_start(ast_b),
    .out_we(we_b), .out_idx(oidx_b), .busy(busy_b), .done(done_b));

  typedef struct {
    bit rst, start, adone;
    int ni, no;
    bit zero, busy;
    int ls;
    bit wre;
    int addr, iidx;
    bit clr, en, ast, we;
    int oidx;
    bit done;
  } cyc_t;

  cyc_t tr[$];
  int errors = 0, checks = 0, cyc = 0, m_addr = 0;
  int obs_wre, obs_we, obs_done, obs_busy, last_addr, last_addr4, first2;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endfunction

  // Idle cycle; config inputs carry junk because they only matter in CFG.
  function automatic cyc_t blank();
    cyc_t c;
    c.rst = 0; c.start = 0; c.adone = 0;
    c.ni = int'($urandom_range(0, 63)); c.no = int'($urandom_range(0, 63));
    c.zero = 0; c.busy = 0; c.ls = 0; c.wre = 0; c.addr = 0; c.iidx = 0;
    c.clr = 0; c.en = 0; c.ast = 0; c.we = 0; c.oidx = 0; c.done = 0;
    return c;
  endfunction

  function automatic cyc_t busy_cyc(int l, bit noise);
    cyc_t c = blank();
    c.busy = 1; c.ls = l;
    if (noise) begin
      c.start = 1'($urandom_range(0, 1));
      c.adone = 1'($urandom_range(0, 1));
    end
    return c;
  endfunction

  task automatic add_idle(int n);
    for (int i = 0; i < n; i++) tr.push_back(blank());
  endtask

  // Expected activity of one full pass: per layer a config cycle, then per
  // neuron n_in read beats, one drain, the activation wait (d extra cycles)
  // and one write, then a layer-advance cycle; finally one done cycle.
  task automatic add_pass(int ni0, int no0, int ni1, int no1, int ni2, int no2,
                          int d, bit noise);
    int ni[3];
    int no[3];
    cyc_t c;
    ni[0] = ni0; ni[1] = ni1; ni[2] = ni2;
    no[0] = no0; no[1] = no1; no[2] = no2;
    c = blank(); c.start = 1; tr.push_back(c);
    m_addr = 0;
    for (int l = 0; l < NL; l++) begin
      c = busy_cyc(l, noise); c.ni = ni[l]; c.no = no[l]; tr.push_back(c);
      if (ni[l] != 0 && no[l] != 0) begin
        for (int j = 0; j < no[l]; j++) begin
          for (int b = 0; b < ni[l]; b++) begin
            c = busy_cyc(l, noise);
            c.wre = 1; c.addr = m_addr; c.iidx = b;
            c.en = (b > 0); c.clr = (b == 1);
            m_addr++;
            tr.push_back(c);
          end
          c = busy_cyc(l, noise); c.en = 1; c.clr = (ni[l] == 1); c.ast = 1;
          tr.push_back(c);
          for (int k = 0; k <= d; k++) begin
            c = busy_cyc(l, noise); c.adone = (k == d); tr.push_back(c);
          end
          c = busy_cyc(l, noise); c.we = 1; c.oidx = j; tr.push_back(c);
        end
      end
      tr.push_back(busy_cyc(l, noise));
    end
    c = busy_cyc(NL - 1, noise); c.done = 1; tr.push_back(c);
  endtask

  // Cut the pending trace at beat 1 of the first layer-1 neuron and reset there.
  task automatic reset_in_layer1();
    cyc_t c;
    int cut = -1;
    foreach (tr[i]) if (cut < 0 && tr[i].wre && tr[i].ls == 1 && tr[i].iidx == 1) cut = i;
    chk("model_cut_found", int'(cut >= 0), 1);
    if (cut >= 0) begin
      tr[cut].rst = 1;
      while (tr.size() > cut + 1) void'(tr.pop_back());
      c = blank(); c.zero = 1; tr.push_back(c);
    end
  endtask

  function automatic int model_count_wre();
    int n = 0;
    foreach (tr[i]) n += int'(tr[i].wre);
    return n;
  endfunction

  function automatic void check_dut(string t, cyc_t e, int amask, int busy, int ls,
      int wre, int addr, int iidx, int clr, int en, int ast, int we, int oidx, int dn);
    chk({t, "_busy"}, busy, int'(e.busy));
    chk({t, "_done"}, dn, int'(e.done));
    chk({t, "_layer_sel"}, ls, e.ls);
    chk({t, "_w_re"}, wre, int'(e.wre));
    chk({t, "_mac_en"}, en, int'(e.en));
    chk({t, "_mac_clr"}, clr, int'(e.clr));
    chk({t, "_act_start"}, ast, int'(e.ast));
    chk({t, "_out_we"}, we, int'(e.we));
    if (e.wre) begin
      chk({t, "_w_addr"}, addr, e.addr & amask);
      chk({t, "_in_idx"}, iidx, e.iidx);
    end
    if (e.we) chk({t, "_out_idx"}, oidx, e.oidx);
  endfunction

  task automatic run_trace();
    obs_wre = 0; obs_we = 0; obs_done = 0; obs_busy = 0;
    last_addr = -1; last_addr4 = -1; first2 = -1;
    foreach (tr[i]) begin
      @(posedge clk);
      #1;
      reset = tr[i].rst; start = tr[i].start; act_done = tr[i].adone;
      n_in = IW'(tr[i].ni); n_out = IW'(tr[i].no);
      @(negedge clk);
      cyc++;
      if (tr[i].zero) begin
        chk("reset_zero_a", int'({ls_a, addr_a, wre_a, iidx_a, clr_a, en_a, ast_a,
                                  we_a, oidx_a, busy_a, done_a} != '0), 0);
        chk("reset_zero_b", int'({ls_b, addr_b, wre_b, iidx_b, clr_b, en_b, ast_b,
                                  we_b, oidx_b, busy_b, done_b} != '0), 0);
      end else begin
        check_dut("a", tr[i], (1 << AW) - 1, int'(busy_a), int'(ls_a), int'(wre_a),
                  int'(addr_a), int'(iidx_a), int'(clr_a), int'(en_a), int'(ast_a),
                  int'(we_a), int'(oidx_a), int'(done_a));
        check_dut("b", tr[i], (1 << AW4) - 1, int'(busy_b), int'(ls_b), int'(wre_b),
                  int'(addr_b), int'(iidx_b), int'(clr_b), int'(en_b), int'(ast_b),
                  int'(we_b), int'(oidx_b), int'(done_b));
      end
      obs_wre  += int'(wre_a);
      obs_we   += int'(we_a);
      obs_done += int'(done_a);
      obs_busy += int'(busy_a);
      if (wre_a) begin
        last_addr = int'(addr_a); last_addr4 = int'(addr_b);
        if (ls_a == 2'd2 && first2 < 0) first2 = int'(addr_a);
      end
    end
    tr.delete();
  endtask

  initial begin
    cyc_t c;
    // Power-up: reset held for two cycles, outputs must read zero.
    c = blank(); c.rst = 1; c.zero = 1; tr.push_back(c);
    c = blank(); c.zero = 1; tr.push_back(c);
    add_idle(2);
    run_trace();

    // Three-layer pass (4,3),(3,2),(2,1), act_done right after act_start.
    add_pass(4, 3, 3, 2, 2, 1, 0, 0);
    add_idle(3);
    chk("model_wre_count", model_count_wre(), 20);
    run_trace();
    chk("pass_wre_count", obs_wre, 20);
    chk("pass_last_addr", last_addr, 19);
    chk("pass_last_addr_wrap4", last_addr4, 3);
    chk("pass_we_count", obs_we, 6);
    chk("pass_done_count", obs_done, 1);
    chk("pass_busy_cycles", obs_busy, 45);

    // Single neuron with four inputs, remaining layers empty.
    add_pass(4, 1, 0, 0, 0, 0, 0, 0);
    add_idle(2);
    run_trace();
    chk("single_wre_count", obs_wre, 4);
    chk("single_busy_cycles", obs_busy, 14);

    // Same neuron with the activation unit stalling ten cycles.
    add_pass(4, 1, 0, 0, 0, 0, 10, 0);
    add_idle(2);
    run_trace();
    chk("stall_we_count", obs_we, 1);
    chk("stall_busy_cycles", obs_busy, 24);

    // Middle layer has no neurons: skipped, addressing carries on contiguously.
    add_pass(2, 2, 3, 0, 2, 1, 0, 0);
    add_idle(2);
    run_trace();
    chk("skip_wre_count", obs_wre, 6);
    chk("skip_we_count", obs_we, 3);
    chk("skip_layer2_first_addr", first2, 4);
    chk("skip_busy_cycles", obs_busy, 22);

    // Stray start/act_done pulses and config churn while busy, single-input layer.
    add_pass(1, 2, 5, 1, 3, 1, 1, 1);
    add_idle(2);
    run_trace();
    chk("noise_wre_count", obs_wre, 10);
    chk("noise_done_count", obs_done, 1);

    // Reset during layer-1 MAC, then a fresh pass restarts from address 0.
    add_pass(2, 1, 3, 2, 1, 1, 0, 0);
    reset_in_layer1();
    add_idle(2);
    add_pass(4, 3, 3, 2, 2, 1, 0, 0);
    add_idle(2);
    run_trace();
    chk("abort_done_count", obs_done, 1);
    chk("abort_restart_last_addr", last_addr, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
